pwm_deadtime_multi: RTL



---
 rtl/pwm_deadtime_pkg.sv | 16 +
 rtl/deadtime_leg.sv | 123 ++++++++++++
 rtl/pwm_deadtime_multi.sv | 75 +++++++
 3 files changed

// File: rtl/pwm_deadtime_pkg.sv
// Shared definitions for the multi-channel dead-time PWM block.
// Contents:
//   leg_state_e : per-leg FSM state encoding (both-off gap, high side on, low side on)
//   HS_OFS/LS_OFS : position of the high/low side bit inside each leg's 2-bit output slot
package pwm_deadtime_pkg;

    typedef enum logic [1:0] {
        ST_DEAD = 2'b00,
        ST_HI   = 2'b01,
        ST_LO   = 2'b10
    } leg_state_e;

    localparam int HS_OFS = 0;
    localparam int LS_OFS = 1;

endpackage

// File: rtl/deadtime_leg.sv
// One complementary gate-drive leg with rise/fall dead time.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   hold              : 1 = force the leg into the gap with the counter kept loaded
//   pwm               : logic PWM command (registered once before use)
//   dt_rise, dt_fall  : gap length before a high-side / low-side turn-on
//   hs, ls            : registered high-side / low-side gate outputs
//   active            : registered, 1 while one side conducts
module deadtime_leg
    import pwm_deadtime_pkg::*;
#(
    parameter int DT_BITS = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               pwm,
    input  logic [DT_BITS-1:0] dt_rise,
    input  logic [DT_BITS-1:0] dt_fall,
    output logic               hs,
    output logic               ls,
    output logic               active
);

    localparam logic [DT_BITS-1:0] DT_ONE = DT_BITS'(1);

    // Gap length for a given target side; zero is stretched to one cycle so
    // a break-before-make gap always exists.
    function automatic logic [DT_BITS-1:0] eff_dt(input logic tgt,
                                                  input logic [DT_BITS-1:0] rise,
                                                  input logic [DT_BITS-1:0] fall);
        logic [DT_BITS-1:0] dt;
        dt = tgt ? rise : fall;
        if (dt == {DT_BITS{1'b0}}) begin
            return DT_ONE;
        end else begin
            return dt;
        end
    endfunction

    leg_state_e         state_r, state_s;
    logic               p_r;
    logic               target_r, target_s;
    logic [DT_BITS-1:0] cnt_r, cnt_s;
    logic [DT_BITS-1:0] load_dt_s;
    logic               hs_r, ls_r, active_r;

    // Next-state logic: leave a conducting side as soon as the command
    // disagrees, and restart the full gap whenever the target moves.
    always_comb begin
        state_s   = state_r;
        target_s  = target_r;
        cnt_s     = cnt_r;
        load_dt_s = eff_dt(p_r, dt_rise, dt_fall);
        if (hold) begin
            state_s  = ST_DEAD;
            target_s = p_r;
            cnt_s    = load_dt_s;
        end else begin
            case (state_r)
                ST_HI: begin
                    if (!p_r) begin
                        state_s  = ST_DEAD;
                        target_s = p_r;
                        cnt_s    = load_dt_s;
                    end else begin
                        state_s  = ST_HI;
                    end
                end
                ST_LO: begin
                    if (p_r) begin
                        state_s  = ST_DEAD;
                        target_s = p_r;
                        cnt_s    = load_dt_s;
                    end else begin
                        state_s  = ST_LO;
                    end
                end
                ST_DEAD: begin
                    if (p_r != target_r) begin
                        target_s = p_r;
                        cnt_s    = load_dt_s;
                    end else if (cnt_r <= DT_ONE) begin
                        state_s  = target_r ? ST_HI : ST_LO;
                    end else begin
                        cnt_s    = cnt_r - DT_ONE;
                    end
                end
                default: begin
                    state_s  = ST_DEAD;
                    target_s = p_r;
                    cnt_s    = load_dt_s;
                end
            endcase
        end
    end

    // State, counter, input register and registered gate outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_r      <= pwm;
            target_r <= pwm;
            cnt_r    <= eff_dt(pwm, dt_rise, dt_fall);
            state_r  <= ST_DEAD;
            hs_r     <= 1'b0;
            ls_r     <= 1'b0;
            active_r <= 1'b0;
        end else begin
            p_r      <= pwm;
            target_r <= target_s;
            cnt_r    <= cnt_s;
            state_r  <= state_s;
            hs_r     <= (state_s == ST_HI);
            ls_r     <= (state_s == ST_LO);
            active_r <= (state_s != ST_DEAD);
        end
    end

    assign hs     = hs_r;
    assign ls     = ls_r;
    assign active = active_r;

endmodule

// File: rtl/pwm_deadtime_multi.sv
// Multi-channel complementary PWM generator with rise/fall dead time,
// enable gating and a latched fault shutdown.
// Ports:
//   CLK, RST        : clock, synchronous active-high reset
//   iENABLE         : 1 = outputs may switch, 0 = all legs held off
//   iFAULT          : level fault request (sets the latch, wins over clear)
//   iFAULT_CLR      : clears the latched fault while iFAULT is low
//   iDEADTIME_RISE  : gap before a high-side turn-on
//   iDEADTIME_FALL  : gap before a low-side turn-on
//   iPWM            : per-leg command, 1 = high side
//   oPWM            : bit 2k = leg k high side, bit 2k+1 = leg k low side
//   oACTIVE         : per-leg, one side conducting
//   oFAULT          : latched fault status
module pwm_deadtime_multi
    import pwm_deadtime_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int DT_BITS  = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  iENABLE,
    input  logic                  iFAULT,
    input  logic                  iFAULT_CLR,
    input  logic [DT_BITS-1:0]    iDEADTIME_RISE,
    input  logic [DT_BITS-1:0]    iDEADTIME_FALL,
    input  logic [CHANNELS-1:0]   iPWM,
    output logic [2*CHANNELS-1:0] oPWM,
    output logic [CHANNELS-1:0]   oACTIVE,
    output logic                  oFAULT
);

    logic                fault_r;
    logic                hold_s;
    logic [CHANNELS-1:0] hs_s;
    logic [CHANNELS-1:0] ls_s;

    // Fault latch: a set request outranks a simultaneous clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fault_r <= 1'b0;
        end else if (iFAULT) begin
            fault_r <= 1'b1;
        end else if (iFAULT_CLR) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= fault_r;
        end
    end

    // The raw fault input is included so outputs drop on the same edge that
    // sets the latch, not one cycle later.
    assign hold_s = ~iENABLE | iFAULT | fault_r;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_leg
        deadtime_leg #(
            .DT_BITS (DT_BITS)
        ) u_leg (
            .clk     (CLK),
            .rst     (RST),
            .hold    (hold_s),
            .pwm     (iPWM[k]),
            .dt_rise (iDEADTIME_RISE),
            .dt_fall (iDEADTIME_FALL),
            .hs      (hs_s[k]),
            .ls      (ls_s[k]),
            .active  (oACTIVE[k])
        );
        assign oPWM[2*k+HS_OFS] = hs_s[k];
        assign oPWM[2*k+LS_OFS] = ls_s[k];
    end

    assign oFAULT = fault_r;

endmodule
